// File: rtl/dmem_pkg.sv
// Shared types and constants for the two-core backing data memory.
package dmem_pkg;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESPOND = 2'd2
    } state_t;

    typedef struct packed {
        logic              op_wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } dmem_req_t;

endpackage

// File: rtl/shared_dmem_responder_if.sv
// Bundle of the two L1 dmem ports plus status, seen from the memory side as slave.
interface shared_dmem_responder_if;
    import dmem_pkg::*;

    // Handshake: a core holds rd_en/wr_en, address and data stable until its
    // dmem_ready pulses for one cycle, and drops the request at the edge that
    // ends that pulse; read data is valid in the ready cycle and then holds.
    logic              dmem_rd_en_0;
    logic              dmem_wr_en_0;
    logic [ADDR_W-1:0] dmem_address_0;
    logic [DATA_W-1:0] data_to_dmem_0;
    logic [DATA_W-1:0] data_from_dmem_0;
    logic              dmem_ready_0;

    logic              dmem_rd_en_1;
    logic              dmem_wr_en_1;
    logic [ADDR_W-1:0] dmem_address_1;
    logic [DATA_W-1:0] data_to_dmem_1;
    logic [DATA_W-1:0] data_from_dmem_1;
    logic              dmem_ready_1;

    logic              busy;
    state_t            dbg_state;

    modport master (
        output dmem_rd_en_0, dmem_wr_en_0, dmem_address_0, data_to_dmem_0,
        output dmem_rd_en_1, dmem_wr_en_1, dmem_address_1, data_to_dmem_1,
        input  data_from_dmem_0, dmem_ready_0,
        input  data_from_dmem_1, dmem_ready_1,
        input  busy, dbg_state
    );

    modport slave (
        input  dmem_rd_en_0, dmem_wr_en_0, dmem_address_0, data_to_dmem_0,
        input  dmem_rd_en_1, dmem_wr_en_1, dmem_address_1, data_to_dmem_1,
        output data_from_dmem_0, dmem_ready_0,
        output data_from_dmem_1, dmem_ready_1,
        output busy, dbg_state
    );

endinterface

// File: rtl/dmem_arbiter_2.sv
// Two-way grant selection; DMEM_RR_ARB_EN selects round-robin, else core 0 has fixed priority.
module dmem_arbiter_2 (
`ifdef DMEM_RR_ARB_EN
    input  logic       clk,
    input  logic       reset,
`endif
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

`ifdef DMEM_RR_ARB_EN
    // last_q is 1 when core 1 held the most recent grant
    logic       last_q;
    logic       last_d;
    logic [1:0] pick;

    always_comb begin
        pick = req;
        if (req == 2'b11) begin
            pick = last_q ? 2'b01 : 2'b10;
        end
        gnt    = advance ? pick : 2'b00;
        last_d = last_q;
        if (advance && (pick != 2'b00)) begin
            last_d = pick[1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    always_comb begin
        gnt = 2'b00;
        if (advance) begin
            gnt = req[0] ? 2'b01 : {req[1], 1'b0};
        end
    end
`endif

endmodule

// File: rtl/shared_dmem_responder.sv
// Serialized word memory shared by two L1 caches; arbitration mode set by DMEM_RR_ARB_EN.
module shared_dmem_responder
    import dmem_pkg::*;
#(
    parameter int LATENCY = 1,
    parameter int DEPTH   = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    shared_dmem_responder_if.slave  bus
);

    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    dmem_req_t         req_q, req_d;
    logic              port_q, port_d;
    logic              ready_0_q, ready_0_d;
    logic              ready_1_q, ready_1_d;
    logic [DATA_W-1:0] rdata_0_q, rdata_0_d;
    logic [DATA_W-1:0] rdata_1_q, rdata_1_d;
    logic              busy_q, busy_d;
    logic              do_write;

    logic [1:0] req;
    logic [1:0] gnt;
    logic       advance;

    assign req = {bus.dmem_rd_en_1 | bus.dmem_wr_en_1,
                  bus.dmem_rd_en_0 | bus.dmem_wr_en_0};
    assign advance = (state_q == IDLE) && (req != 2'b00);

    dmem_arbiter_2 u_arb (
`ifdef DMEM_RR_ARB_EN
        .clk     (clk),
        .reset   (reset),
`endif
        .req     (req),
        .advance (advance),
        .gnt     (gnt)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_d     = req_q;
        port_d    = port_q;
        ready_0_d = 1'b0;
        ready_1_d = 1'b0;
        rdata_0_d = rdata_0_q;
        rdata_1_d = rdata_1_q;
        do_write  = 1'b0;
        case (state_q)
            IDLE: begin
                if (advance) begin
                    port_d = gnt[1];
                    if (gnt[1]) begin
                        req_d.op_wr = bus.dmem_wr_en_1;
                        req_d.addr  = bus.dmem_address_1;
                        req_d.data  = bus.data_to_dmem_1;
                    end else begin
                        req_d.op_wr = bus.dmem_wr_en_0;
                        req_d.addr  = bus.dmem_address_0;
                        req_d.data  = bus.data_to_dmem_0;
                    end
                    cnt_d   = LAT_M1;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d  = RESPOND;
                    do_write = req_q.op_wr;
                    // A write (including rd+wr together) leaves the read register untouched
                    if (port_q) begin
                        ready_1_d = 1'b1;
                        if (!req_q.op_wr) rdata_1_d = mem[req_q.addr];
                    end else begin
                        ready_0_d = 1'b1;
                        if (!req_q.op_wr) rdata_0_d = mem[req_q.addr];
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESPOND: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            req_q     <= '0;
            port_q    <= 1'b0;
            ready_0_q <= 1'b0;
            ready_1_q <= 1'b0;
            rdata_0_q <= '0;
            rdata_1_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            req_q     <= req_d;
            port_q    <= port_d;
            ready_0_q <= ready_0_d;
            ready_1_q <= ready_1_d;
            rdata_0_q <= rdata_0_d;
            rdata_1_q <= rdata_1_d;
            busy_q    <= busy_d;
        end
    end

    // Array is never cleared; reset only blocks an in-flight commit
    always_ff @(posedge clk) begin
        if (!reset && do_write) begin
            mem[req_q.addr] <= req_q.data;
        end
    end

    assign bus.dmem_ready_0     = ready_0_q;
    assign bus.dmem_ready_1     = ready_1_q;
    assign bus.data_from_dmem_0 = rdata_0_q;
    assign bus.data_from_dmem_1 = rdata_1_q;
    assign bus.busy             = busy_q;
    assign bus.dbg_state        = state_q;

endmodule

// File: tb/tb_shared_dmem_responder.sv
// Randomized scoreboard bench for shared_dmem_responder against a word-level memory model.
module tb_shared_dmem_responder;
    import dmem_pkg::*;

    localparam int LAT = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    shared_dmem_responder_if bus();

    shared_dmem_responder #(.LATENCY(LAT), .DEPTH(1024)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] exp_q0[$];
    logic [31:0] exp_q1[$];
    int          order_q[$];

    logic [31:0] ref_mem [1024];
    logic [31:0] last_rd [2];
    int          last_grant;
    logic [9:0]  pool [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: apply one access to the word model in grant order and queue its response
    task automatic expect_op(input int p, input bit rd, input bit wr,
                             input logic [9:0] a, input logic [31:0] d);
        logic [31:0] e;
        if (wr) begin
            ref_mem[a] = d;
            e = last_rd[p];
        end else begin
            e = ref_mem[a];
        end
        last_rd[p] = e;
        if (p == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
        order_q.push_back(p);
        last_grant = p;
        if (!rd && !wr) $display("note: empty request issued");
    endtask

    task automatic mon_port(input int p, input logic [31:0] data);
        logic [31:0] e;
        if (order_q.size() == 0 || (p == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_ready: port %0d pulsed ready, expected no pending access", p);
        end else begin
            check("grant_order", 32'(p), 32'(order_q.pop_front()));
            e = (p == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            check(p == 0 ? "rdata_0" : "rdata_1", data, e);
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (bus.dmem_ready_0 === 1'b1) mon_port(0, bus.data_from_dmem_0);
            if (bus.dmem_ready_1 === 1'b1) mon_port(1, bus.data_from_dmem_1);
        end
    end

    task automatic set_port(input int p, input bit rd, input bit wr,
                            input logic [9:0] a, input logic [31:0] d);
        if (p == 0) begin
            bus.dmem_rd_en_0 = rd; bus.dmem_wr_en_0 = wr;
            bus.dmem_address_0 = a; bus.data_to_dmem_0 = d;
        end else begin
            bus.dmem_rd_en_1 = rd; bus.dmem_wr_en_1 = wr;
            bus.dmem_address_1 = a; bus.data_to_dmem_1 = d;
        end
    endtask

    // Hold the request until this port's ready; exp_edges==0 skips latency checking
    task automatic drive_port(input int p, input bit rd, input bit wr,
                              input logic [9:0] a, input logic [31:0] d, input int exp_edges);
        int  n;
        bit  seen;
        n = 0;
        seen = 1'b0;
        set_port(p, rd, wr, a, d);
        while (!seen && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1 && exp_edges > 0) check("busy_in_access", 32'(bus.busy), 32'd1);
            if ((p == 0 ? bus.dmem_ready_0 : bus.dmem_ready_1) === 1'b1) seen = 1'b1;
        end
        set_port(p, 1'b0, 1'b0, '0, '0);
        if (!seen) begin
            n_vec++;
            n_err++;
            $display("FAIL ready_timeout: port %0d got no ready in %0d cycles, expected one", p, n);
        end else if (exp_edges > 0) begin
            check(p == 0 ? "latency_0" : "latency_1", 32'(n), 32'(exp_edges));
        end
    endtask

    task automatic gap();
        @(posedge clk);
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
    endtask

    task automatic single(input int p, input bit rd, input bit wr,
                          input logic [9:0] a, input logic [31:0] d);
        check("idle_busy", 32'(bus.busy), 32'd0);
        expect_op(p, rd, wr, a, d);
        drive_port(p, rd, wr, a, d, LAT + 1);
        gap();
    endtask

    task automatic pair(input bit rd0, input bit wr0, input logic [9:0] a0, input logic [31:0] d0,
                        input bit rd1, input bit wr1, input logic [9:0] a1, input logic [31:0] d1);
        int first;
`ifdef DMEM_RR_ARB_EN
        first = (last_grant == 1) ? 0 : 1;
`else
        first = 0;
`endif
        check("idle_busy", 32'(bus.busy), 32'd0);
        if (first == 0) begin
            expect_op(0, rd0, wr0, a0, d0);
            expect_op(1, rd1, wr1, a1, d1);
        end else begin
            expect_op(1, rd1, wr1, a1, d1);
            expect_op(0, rd0, wr0, a0, d0);
        end
        fork
            drive_port(0, rd0, wr0, a0, d0, first == 0 ? LAT + 1 : 2 * LAT + 3);
            drive_port(1, rd1, wr1, a1, d1, first == 1 ? LAT + 1 : 2 * LAT + 3);
        join
        gap();
    endtask

    task automatic check_reset_outputs();
        check("rst_ready_0", 32'(bus.dmem_ready_0), 32'd0);
        check("rst_ready_1", 32'(bus.dmem_ready_1), 32'd0);
        check("rst_data_0", bus.data_from_dmem_0, 32'd0);
        check("rst_data_1", bus.data_from_dmem_1, 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_state", 32'(bus.dbg_state), 32'(IDLE));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        bit          rd, wr, rd1, wr1;
        logic [31:0] old20;
        pool = '{10'h005, 10'h010, 10'h020, 10'h3FF, 10'h000, 10'h155, 10'h2AA, 10'h0FF};
        last_rd    = '{32'd0, 32'd0};
        last_grant = 1;
        reset = 1'b1;
        set_port(0, 1'b0, 1'b0, '0, '0);
        set_port(1, 1'b0, 1'b0, '0, '0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_reset_outputs();
        gap();

        // Preload every address the random phase may read
        for (int i = 0; i < 8; i++) begin
            single(int'($urandom_range(0, 1)), 1'b0, 1'b1, pool[i], $urandom);
        end

        single(0, 1'b0, 1'b1, 10'h005, 32'hDEADBEEF);
        single(0, 1'b1, 1'b0, 10'h005, 32'h0);

        pair(1'b1, 1'b0, 10'h005, 32'h0, 1'b1, 1'b0, 10'h010, 32'h0);
        pair(1'b1, 1'b0, 10'h010, 32'h0, 1'b1, 1'b0, 10'h005, 32'h0);

        // Core 1 write is in flight when core 0's read of the same word arrives
        check("idle_busy", 32'(bus.busy), 32'd0);
        expect_op(1, 1'b0, 1'b1, 10'h3FF, 32'h12345678);
        expect_op(0, 1'b1, 1'b0, 10'h3FF, 32'h0);
        fork
            drive_port(1, 1'b0, 1'b1, 10'h3FF, 32'h12345678, LAT + 1);
            begin
                @(posedge clk);
                #1;
                drive_port(0, 1'b1, 1'b0, 10'h3FF, 32'h0, 0);
            end
        join
        gap();

        single(0, 1'b1, 1'b1, 10'h010, 32'hA5A5A5A5);
        single(0, 1'b1, 1'b0, 10'h010, 32'h0);

        // Reset while a write is still counting down
        old20 = ref_mem[10'h020];
        check("idle_busy", 32'(bus.busy), 32'd0);
        set_port(0, 1'b0, 1'b1, 10'h020, 32'h1);
        @(posedge clk);
        #1;
        check("busy_before_abort", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        set_port(0, 1'b0, 1'b0, '0, '0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        last_rd    = '{32'd0, 32'd0};
        last_grant = 1;
        check_reset_outputs();
        gap();
        check("model_0x020_kept", ref_mem[10'h020], old20);
        single(1, 1'b1, 1'b0, 10'h020, 32'h0);

        for (int i = 0; i < 40; i++) begin
            int op0, op1;
            op0 = int'($urandom_range(0, 2));
            op1 = int'($urandom_range(0, 2));
            rd  = (op0 != 1);
            wr  = (op0 != 0);
            rd1 = (op1 != 1);
            wr1 = (op1 != 0);
            if ($urandom_range(0, 1) == 0) begin
                single(int'($urandom_range(0, 1)), rd, wr, pool[$urandom_range(0, 7)], $urandom);
            end else begin
                pair(rd, wr, pool[$urandom_range(0, 7)], $urandom,
                     rd1, wr1, pool[$urandom_range(0, 7)], $urandom);
            end
        end

        repeat (5) @(posedge clk);
        check("pending_left", 32'(exp_q0.size() + exp_q1.size() + order_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
